// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among result producers
// into a single registered broadcast slot with backpressure and flush.
module cdb_arbiter #(
  parameter int N_REQ    = 3,
  parameter int ROB_BITS = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ROB_BITS-1:0] req_rob,
  input  logic [N_REQ*32-1:0]       req_result,
  input  logic [N_REQ-1:0]          req_branch,
  input  logic [N_REQ-1:0]          req_from_mem,
  input  logic                      cdb_ready,
  output logic [N_REQ-1:0]          yummy,
  output logic                      cdb_valid,
  output logic [ROB_BITS-1:0]       cdb_rob,
  output logic [31:0]               cdb_result,
  output logic                      cdb_branch,
  output logic                      cdb_from_mem,
  output logic [1:0]                cdb_src
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0]       rr_ptr;
  logic [PW-1:0]       nxt_ptr;
  logic                open;
  logic                found;
  logic                grant;
  logic [N_REQ-1:0]    win_oh;
  logic [ROB_BITS-1:0] sel_rob;
  logic [31:0]         sel_res;
  logic                sel_br;
  logic                sel_mem;
  logic [1:0]          sel_src;
  int                  t;

  assign open  = !cdb_valid || cdb_ready;
  assign grant = open && !flush && found;

  // Scan offsets from rr_ptr upward; first valid requester wins.
  always_comb begin
    found   = 1'b0;
    win_oh  = '0;
    sel_rob = '0;
    sel_res = '0;
    sel_br  = 1'b0;
    sel_mem = 1'b0;
    sel_src = 2'd0;
    nxt_ptr = rr_ptr;
    t       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      t = int'(rr_ptr) + i;
      if (t >= N_REQ) t = t - N_REQ;
      for (int j = 0; j < N_REQ; j++) begin
        if (!found && j == t && req_valid[j]) begin
          found     = 1'b1;
          win_oh[j] = 1'b1;
          sel_rob   = req_rob[j*ROB_BITS +: ROB_BITS];
          sel_res   = req_result[j*32 +: 32];
          sel_br    = req_branch[j];
          sel_mem   = req_from_mem[j];
          sel_src   = 2'(j);
          nxt_ptr   = (j == N_REQ-1) ? '0 : PW'(j + 1);
        end
      end
    end
  end

  assign yummy = (grant && !reset) ? win_oh : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cdb_valid    <= 1'b0;
      cdb_rob      <= '0;
      cdb_result   <= '0;
      cdb_branch   <= 1'b0;
      cdb_from_mem <= 1'b0;
      cdb_src      <= 2'd0;
      rr_ptr       <= '0;
    end else if (flush) begin
      cdb_valid <= 1'b0;
    end else if (open) begin
      if (found) begin
        cdb_valid    <= 1'b1;
        cdb_rob      <= sel_rob;
        cdb_result   <= sel_res;
        cdb_branch   <= sel_br;
        cdb_from_mem <= sel_mem;
        cdb_src      <= sel_src;
        rr_ptr       <= nxt_ptr;
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: expected packets queued at grant,
// compared against the broadcast register after the edge.
module tb_cdb_arbiter;

  typedef struct packed {
    logic        v;
    logic [4:0]  rob;
    logic [31:0] res;
    logic        br;
    logic        mem;
    logic [1:0]  src;
  } pkt_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [2:0]  req_valid;
  logic [14:0] req_rob;
  logic [95:0] req_result;
  logic [2:0]  req_branch;
  logic [2:0]  req_from_mem;
  logic        cdb_ready;
  logic [2:0]  yummy;
  logic        cdb_valid;
  logic [4:0]  cdb_rob;
  logic [31:0] cdb_result;
  logic        cdb_branch;
  logic        cdb_from_mem;
  logic [1:0]  cdb_src;

  logic [4:0]  r_rob [3];
  logic [31:0] r_res [3];
  logic        r_br  [3];
  logic        r_mem [3];

  pkt_t sb[$];
  pkt_t got;
  pkt_t exp;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_rob      = '0;
    req_result   = '0;
    req_branch   = '0;
    req_from_mem = '0;
    for (int i = 0; i < 3; i++) begin
      req_rob[i*5 +: 5]     = r_rob[i];
      req_result[i*32 +: 32] = r_res[i];
      req_branch[i]         = r_br[i];
      req_from_mem[i]       = r_mem[i];
    end
  end

  cdb_arbiter #(.N_REQ(3), .ROB_BITS(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_rob      (req_rob),
    .req_result   (req_result),
    .req_branch   (req_branch),
    .req_from_mem (req_from_mem),
    .cdb_ready    (cdb_ready),
    .yummy        (yummy),
    .cdb_valid    (cdb_valid),
    .cdb_rob      (cdb_rob),
    .cdb_result   (cdb_result),
    .cdb_branch   (cdb_branch),
    .cdb_from_mem (cdb_from_mem),
    .cdb_src      (cdb_src)
  );

  function automatic pkt_t mk(int i);
    return {1'b1, r_rob[i], r_res[i], r_br[i], r_mem[i], 2'(i)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, logic [4:0] rob, logic [31:0] res,
                         logic br, logic mem);
    r_rob[i] = rob;
    r_res[i] = res;
    r_br[i]  = br;
    r_mem[i] = mem;
  endtask

  task automatic test_reset();
    req_valid = 3'b111;
    cdb_ready = 1'b1;
    #3;
    got = {cdb_valid, cdb_rob, cdb_result, cdb_branch, cdb_from_mem, cdb_src};
    checks++;
    if (got !== '0 || yummy !== 3'b000) begin
      errors++;
      $display("FAIL reset_state: got pkt=%h yummy=%b, want 0/000", got, yummy);
    end
    tick();
    got = {cdb_valid, cdb_rob, cdb_result, cdb_branch, cdb_from_mem, cdb_src};
    checks++;
    if (got !== '0 || yummy !== 3'b000) begin
      errors++;
      $display("FAIL reset_hold: got pkt=%h yummy=%b, want 0/000", got, yummy);
    end
    reset     = 1'b0;
    req_valid = 3'b000;
  endtask

  task automatic test_single_mem();
    set_req(2, 5'd7, 32'hDEADBEEF, 1'b0, 1'b1);
    req_valid = 3'b100;
    cdb_ready = 1'b1;
    #2;
    checks++;
    if (yummy !== 3'b100) begin
      errors++;
      $display("FAIL single_yummy: got %b want 100", yummy);
    end
    sb.push_back(mk(2));
    tick();
    req_valid = 3'b000;
    got = {cdb_valid, cdb_rob, cdb_result, cdb_branch, cdb_from_mem, cdb_src};
    exp = sb.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL single_pkt: got %h want %h", got, exp);
    end
    #2;
    checks++;
    if (yummy !== 3'b000) begin
      errors++;
      $display("FAIL idle_yummy: got %b want 000", yummy);
    end
    tick();
    checks++;
    if (cdb_valid !== 1'b0 || cdb_rob !== 5'd7 || cdb_result !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL idle_clear: got v=%b rob=%0d res=%h want 0/7/deadbeef",
               cdb_valid, cdb_rob, cdb_result);
    end
  endtask

  task automatic test_round_robin();
    int seq[4] = '{0, 1, 2, 0};
    set_req(0, 5'd1, 32'h11111111, 1'b1, 1'b0);
    set_req(1, 5'd2, 32'h22222222, 1'b0, 1'b0);
    req_valid = 3'b111;
    cdb_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #2;
      checks++;
      if (yummy !== 3'(1 << seq[k])) begin
        errors++;
        $display("FAIL rr_yummy[%0d]: got %b want grant to %0d", k, yummy, seq[k]);
      end
      sb.push_back(mk(seq[k]));
      tick();
      got = {cdb_valid, cdb_rob, cdb_result, cdb_branch, cdb_from_mem, cdb_src};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rr_pkt[%0d]: got %h want %h", k, got, exp);
      end
    end
    req_valid = 3'b000;
  endtask

  task automatic test_backpressure();
    pkt_t held;
    held      = exp;
    cdb_ready = 1'b0;
    req_valid = 3'b001;
    set_req(0, 5'd12, 32'h12345678, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #2;
      checks++;
      if (yummy !== 3'b000) begin
        errors++;
        $display("FAIL bp_yummy[%0d]: got %b want 000", k, yummy);
      end
      tick();
      got = {cdb_valid, cdb_rob, cdb_result, cdb_branch, cdb_from_mem, cdb_src};
      checks++;
      if (got !== held) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got %h want %h", k, got, held);
      end
    end
    cdb_ready = 1'b1;
    #2;
    checks++;
    if (yummy !== 3'b001) begin
      errors++;
      $display("FAIL bp_release_yummy: got %b want 001", yummy);
    end
    sb.push_back(mk(0));
    tick();
    req_valid = 3'b000;
    got = {cdb_valid, cdb_rob, cdb_result, cdb_branch, cdb_from_mem, cdb_src};
    exp = sb.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL bp_release_pkt: got %h want %h", got, exp);
    end
  endtask

  task automatic test_back_to_back();
    req_valid = 3'b010;
    cdb_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_req(1, 5'(16 + k), 32'hB0B0_0000 + 32'(k), k[0], 1'b0);
      #2;
      checks++;
      if (yummy !== 3'b010) begin
        errors++;
        $display("FAIL b2b_yummy[%0d]: got %b want 010", k, yummy);
      end
      sb.push_back(mk(1));
      tick();
      got = {cdb_valid, cdb_rob, cdb_result, cdb_branch, cdb_from_mem, cdb_src};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL b2b_pkt[%0d]: got %h want %h", k, got, exp);
      end
    end
    req_valid = 3'b000;
  endtask

  task automatic test_ready_ignored();
    tick();
    checks++;
    if (cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_valid: got %b want 0", cdb_valid);
    end
    // rr_ptr now points at 2; only requester 0 asks, with ready low
    cdb_ready = 1'b0;
    req_valid = 3'b001;
    #2;
    checks++;
    if (yummy !== 3'b001) begin
      errors++;
      $display("FAIL empty_grant_yummy: got %b want 001", yummy);
    end
    sb.push_back(mk(0));
    tick();
    req_valid = 3'b000;
    got = {cdb_valid, cdb_rob, cdb_result, cdb_branch, cdb_from_mem, cdb_src};
    exp = sb.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL empty_grant_pkt: got %h want %h", got, exp);
    end
  endtask

  task automatic test_flush();
    flush     = 1'b1;
    cdb_ready = 1'b1;
    req_valid = 3'b011;
    #2;
    checks++;
    if (yummy !== 3'b000) begin
      errors++;
      $display("FAIL flush_yummy: got %b want 000", yummy);
    end
    tick();
    flush = 1'b0;
    checks++;
    if (cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_valid: got %b want 0", cdb_valid);
    end
    // rr_ptr must still be 1, so requester 1 beats requester 0
    #1;
    checks++;
    if (yummy !== 3'b010) begin
      errors++;
      $display("FAIL flush_ptr_yummy: got %b want 010", yummy);
    end
    sb.push_back(mk(1));
    tick();
    req_valid = 3'b000;
    cdb_ready = 1'b0;
    got = {cdb_valid, cdb_rob, cdb_result, cdb_branch, cdb_from_mem, cdb_src};
    exp = sb.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL flush_after_pkt: got %h want %h", got, exp);
    end
  endtask

  task automatic test_async_reset();
    #2;
    req_valid = 3'b111;
    reset     = 1'b1;
    #1;
    got = {cdb_valid, cdb_rob, cdb_result, cdb_branch, cdb_from_mem, cdb_src};
    checks++;
    if (got !== '0 || yummy !== 3'b000) begin
      errors++;
      $display("FAIL async_reset: got pkt=%h yummy=%b want 0/000", got, yummy);
    end
    sb.delete();
    tick();
    reset     = 1'b0;
    req_valid = 3'b110;
    cdb_ready = 1'b1;
    #2;
    checks++;
    if (yummy !== 3'b010) begin
      errors++;
      $display("FAIL post_reset_yummy: got %b want 010", yummy);
    end
    sb.push_back(mk(1));
    tick();
    req_valid = 3'b000;
    got = {cdb_valid, cdb_rob, cdb_result, cdb_branch, cdb_from_mem, cdb_src};
    exp = sb.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL post_reset_pkt: got %h want %h", got, exp);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d leftover want 0", sb.size());
    end
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    req_valid = 3'b000;
    cdb_ready = 1'b0;
    for (int i = 0; i < 3; i++) set_req(i, 5'd0, 32'd0, 1'b0, 1'b0);
    test_reset();
    test_single_mem();
    test_round_robin();
    test_backpressure();
    test_back_to_back();
    test_ready_ignored();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter N_REQ, default 3; number of requesters (0=ALU, 1=branch, 2=memory).
REQ-002 Parameter ROB_BITS, default 5; ROB entry index width.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  synchronous pipeline flush (mispredict).
REQ-006 req_valid  input  N_REQ  per-requester result pending; held until yummy.
REQ-007 req_rob  input  N_REQ*ROB_BITS  per-requester destination ROB entry.
REQ-008 req_result  input  N_REQ*32  per-requester result data.
REQ-009 req_branch  input  N_REQ  per-requester branch outcome bit.
REQ-010 req_from_mem  input  N_REQ  per-requester load-result flag.
REQ-011 cdb_ready  input  1  consumers (ROB, RS) accept the current broadcast this cycle.
REQ-012 yummy  output  N_REQ  one-hot or zero; grant/consume pulse to requester.
REQ-013 cdb_valid  output  1  broadcast register holds a valid packet.
REQ-014 cdb_rob  output  ROB_BITS  broadcast destination ROB entry.
REQ-015 cdb_result  output  32  broadcast result.
REQ-016 cdb_branch  output  1  broadcast branch outcome.
REQ-017 cdb_from_mem  output  1  broadcast load flag.
REQ-018 cdb_src  output  2  index of requester that produced the current broadcast.

Function
REQ-019 Output packet (cdb_*) SHALL be fully registered; no combinational path from req_* to cdb_*.
REQ-020 Register "open" = !cdb_valid | cdb_ready; grant SHALL occur only when open, flush=0, and any req_valid=1.
REQ-021 Grant: yummy[w]=1 combinationally in that cycle; at the edge, cdb_* loads requester w fields, cdb_valid=1, cdb_src=w.
REQ-022 Requester SHALL drop/advance req_valid on the same edge it sees yummy; arbiter assumes no re-grant of the same packet.
REQ-023 Open with no request: cdb_valid cleared at the edge; other cdb_* fields hold.
REQ-024 Not open (cdb_valid=1, cdb_ready=0): cdb_* hold, yummy=0.
REQ-025 Arbitration: round-robin; search starts at pointer rr_ptr, ascending with wrap N_REQ-1 -> 0.
REQ-026 After a grant to w, rr_ptr SHALL become (w+1) mod N_REQ; unchanged when no grant.
REQ-027 Only requesters with req_valid=1 SHALL be eligible; a single requester SHALL be granted every open cycle (back-to-back, one packet per cycle).
REQ-028 Fairness: any continuously valid requester SHALL be granted within N_REQ open cycles.
REQ-029 flush=1: yummy=0, cdb_valid cleared at the edge, rr_ptr unchanged; flush overrides cdb_ready and all requests.
REQ-030 cdb_ready while cdb_valid=0 SHALL be ignored.
REQ-031 yummy SHALL never be asserted to a requester with req_valid=0, and at most one bit SHALL be set.

Reset
REQ-032 reset=1 SHALL asynchronously clear cdb_valid, cdb_rob, cdb_result, cdb_branch, cdb_from_mem, cdb_src and rr_ptr to 0.
REQ-033 yummy SHALL be 0 while reset=1; first grant possible on the first edge after reset deasserts.
REQ-034 Reset mid-broadcast SHALL discard the held packet; no yummy is re-issued for it.

Verification
REQ-035 Single mem request: req_valid=3'b100, rob=7, result=0xDEADBEEF, from_mem=1, cdb_ready=1 -> yummy=3'b100 same cycle; next cycle cdb_valid=1, cdb_rob=7, cdb_result=0xDEADBEEF, cdb_src=2.
REQ-036 All three valid continuously, cdb_ready=1, rr_ptr=0 -> grants 0,1,2,0 on consecutive cycles; cdb_src sequence 0,1,2,0.
REQ-037 Backpressure: cdb_valid=1, cdb_ready=0 for 3 cycles with req_valid=3'b001 -> yummy=0 and cdb_* stable for 3 cycles; grant on cycle cdb_ready rises.
REQ-038 Flush: cdb_valid=1, req_valid=3'b011, flush=1 -> yummy=0, next cycle cdb_valid=0, rr_ptr unchanged.
REQ-039 Async reset asserted mid-cycle with cdb_valid=1 -> all outputs 0 immediately; after release, req_valid=3'b110 -> first grant to requester 1.
